// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the two requester ports and the memory-side port of the pattern
// memory arbiter.
//   Requester A (fill engine)  : ia_req, ia_we, ia_addr, ia_wdata -> oa_gnt, oa_rvalid, oa_rdata
//   Requester B (host bridge)  : ib_req, ib_we, ib_addr, ib_wdata -> ob_gnt, ob_rvalid, ob_rdata
//   Memory macro               : omem_addr, omem_wdata, omem_we, omem_en -> imem_rdata
// Modports:
//   slave  : the arbiter itself
//   master : the environment (both requesters plus the memory macro)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              ia_req;
  logic              ia_we;
  logic [ADDR_W-1:0] ia_addr;
  logic [DATA_W-1:0] ia_wdata;
  logic              oa_gnt;
  logic              oa_rvalid;
  logic [DATA_W-1:0] oa_rdata;

  logic              ib_req;
  logic              ib_we;
  logic [ADDR_W-1:0] ib_addr;
  logic [DATA_W-1:0] ib_wdata;
  logic              ob_gnt;
  logic              ob_rvalid;
  logic [DATA_W-1:0] ob_rdata;

  logic [ADDR_W-1:0] omem_addr;
  logic [DATA_W-1:0] omem_wdata;
  logic              omem_we;
  logic              omem_en;
  logic [DATA_W-1:0] imem_rdata;

  modport slave (
    input  ia_req, ia_we, ia_addr, ia_wdata,
    output oa_gnt, oa_rvalid, oa_rdata,
    input  ib_req, ib_we, ib_addr, ib_wdata,
    output ob_gnt, ob_rvalid, ob_rdata,
    output omem_addr, omem_wdata, omem_we, omem_en,
    input  imem_rdata
  );

  modport master (
    output ia_req, ia_we, ia_addr, ia_wdata,
    input  oa_gnt, oa_rvalid, oa_rdata,
    output ib_req, ib_we, ib_addr, ib_wdata,
    input  ob_gnt, ob_rvalid, ob_rdata,
    input  omem_addr, omem_wdata, omem_we, omem_en,
    output imem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single port of the 64K x 8 pattern memory between the fill
// engine (A) and the serial host bridge (B). Round-robin arbitration with a
// per-owner burst limit that applies only while the other side is waiting.
// Grants are combinational; memory-side signals are registered; read data
// returns two cycles after the grant with an rvalid pulse to the issuer.
// Ports:
//   iclk  : clock, all logic on the rising edge
//   irst  : synchronous active-high reset
//   bus   : mem_port_arbiter_if.slave (requester A/B ports and memory port)
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input logic                iclk,
  input logic                irst,
  mem_port_arbiter_if.slave  bus
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  owner_t            owner;
  owner_t            last;
  owner_t            winner;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_en;
  logic              tag_b;     // access now on the memory port belongs to B
  logic              a_rvalid;
  logic              b_rvalid;

  // The current owner keeps the port while it requests, unless it has used
  // up its burst and the other side is waiting. Otherwise round-robin on
  // ties, or the sole requester.
  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = OWN_NONE;
    if (owner == OWN_A && bus.ia_req && (cnt < CNT_MAX || !bus.ib_req)) begin
      winner = OWN_A;
    end else if (owner == OWN_B && bus.ib_req && (cnt < CNT_MAX || !bus.ia_req)) begin
      winner = OWN_B;
    end else if (bus.ia_req && bus.ib_req) begin
      winner = (last == OWN_A) ? OWN_B : OWN_A;
    end else if (bus.ia_req) begin
      winner = OWN_A;
    end else if (bus.ib_req) begin
      winner = OWN_B;
    end
  end

  // NOTE: all state uses non-blocking assignments and a synchronous reset;
  // the access granted during a reset cycle is dropped by the reset branch.
  always_ff @(posedge iclk) begin
    if (irst) begin
      owner     <= OWN_NONE;
      last      <= OWN_B;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_en    <= 1'b0;
      tag_b     <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
    end else begin
      owner <= winner;

      // Burst counter: saturates at MAX_BURST, restarts at 1 on a switch.
      if (winner == OWN_NONE) begin
        cnt <= '0;
      end else if (winner != owner) begin
        cnt <= CNT_ONE;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end

      if (winner != OWN_NONE) begin
        last <= winner;
      end

      mem_en <= (winner != OWN_NONE);
      case (winner)
        OWN_A: begin
          mem_we    <= bus.ia_we;
          mem_addr  <= bus.ia_addr;
          mem_wdata <= bus.ia_wdata;
          tag_b     <= 1'b0;
        end
        OWN_B: begin
          mem_we    <= bus.ib_we;
          mem_addr  <= bus.ib_addr;
          mem_wdata <= bus.ib_wdata;
          tag_b     <= 1'b1;
        end
        default: begin
          // Address and data hold; only the strobes drop.
          mem_we <= 1'b0;
        end
      endcase

      // The memory returns read data one cycle after the access is issued;
      // the tag steers the valid pulse to the requester that issued it.
      a_rvalid <= mem_en && !mem_we && !tag_b;
      b_rvalid <= mem_en && !mem_we &&  tag_b;
    end
  end

  assign bus.oa_gnt     = (winner == OWN_A);
  assign bus.ob_gnt     = (winner == OWN_B);
  assign bus.oa_rvalid  = a_rvalid;
  assign bus.ob_rvalid  = b_rvalid;
  assign bus.oa_rdata   = bus.imem_rdata;
  assign bus.ob_rdata   = bus.imem_rdata;
  assign bus.omem_addr  = mem_addr;
  assign bus.omem_wdata = mem_wdata;
  assign bus.omem_we    = mem_we;
  assign bus.omem_en    = mem_en;

endmodule
